// File: rtl/uart2wb.sv
// rtl/uart2wb.sv - UART-framed command port driving a single-beat Wishbone classic master
module uart2wb #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int clk_per_bit    = 217,
    parameter int timeout_cycles = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [addr_width-1:0]   wb_adr,
    output logic [data_width-1:0]   wb_dat_o,
    output logic [data_width/8-1:0] wb_sel,
    input  logic [data_width-1:0]   wb_dat_i,
    input  logic                    wb_ack,
    input  logic                    wb_err
);

    localparam int NA   = addr_width / 8;
    localparam int ND   = data_width / 8;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int IW   = $clog2(NMAX + 1);
    localparam int CW   = $clog2(clk_per_bit);
    localparam int TW   = $clog2(timeout_cycles + 1);
    localparam int SW   = $clog2(ND + 2);
    localparam int HALF = clk_per_bit / 2;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    // Every transfer uses the full bus width
    assign wb_sel = '1;

    // ------------------------------------------------------------------
    // UART receive
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_valid;
    logic            rx_ferr;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit timing: re-check start at half a bit, then sample each bit at its centre
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_HUNT;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_HUNT: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CW'(HALF - 1)) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_state <= RX_HUNT;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CW'(clk_per_bit - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CW'(clk_per_bit - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_HUNT;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command parser / Wishbone master
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {P_IDLE, P_ADR, P_DAT, P_WB, P_SEND} p_state_t;

    p_state_t              p_state;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tcnt;
    logic [data_width+7:0] resp_sr;
    logic [SW-1:0]         send_left;

    logic                  tx_active;
    logic [CW-1:0]         tx_cnt;
    logic [3:0]            tx_bit;
    logic [9:0]            tx_shift;
    logic                  tx_ready;
    logic                  tx_load;

    // Little-endian fields: each new byte enters at the top and slides down
    logic [addr_width+7:0] adr_cat;
    logic [data_width+7:0] dat_cat;
    assign adr_cat = {rx_shift, wb_adr};
    assign dat_cat = {rx_shift, wb_dat_o};

    // The transmitter can take a byte when idle or in the last clock of a stop bit,
    // which is what gives gap-free back-to-back response bytes
    assign tx_ready = !tx_active || ((tx_cnt == CW'(clk_per_bit - 1)) && (tx_bit == 4'd9));
    assign tx_load  = (p_state == P_SEND) && (send_left != '0) && tx_ready;

    // Frame parsing, the Wishbone cycle with timeout, and response sequencing
    always_ff @(posedge clock) begin
        if (reset) begin
            p_state   <= P_IDLE;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            wb_adr    <= '0;
            wb_dat_o  <= '0;
            idx       <= '0;
            tcnt      <= '0;
            resp_sr   <= '0;
            send_left <= '0;
        end else begin
            case (p_state)
                P_IDLE: begin
                    if (rx_valid && (rx_shift == CMD_WR || rx_shift == CMD_RD)) begin
                        wb_we   <= (rx_shift == CMD_WR);
                        idx     <= '0;
                        p_state <= P_ADR;
                    end
                end
                P_ADR: begin
                    if (rx_ferr) begin
                        p_state <= P_IDLE;
                    end else if (rx_valid) begin
                        wb_adr <= adr_cat[addr_width+7:8];
                        if (idx == IW'(NA - 1)) begin
                            idx <= '0;
                            if (wb_we) begin
                                p_state <= P_DAT;
                            end else begin
                                wb_cyc  <= 1'b1;
                                wb_stb  <= 1'b1;
                                tcnt    <= '0;
                                p_state <= P_WB;
                            end
                        end else if (idx != IW'(NMAX)) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                P_DAT: begin
                    if (rx_ferr) begin
                        p_state <= P_IDLE;
                    end else if (rx_valid) begin
                        wb_dat_o <= dat_cat[data_width+7:8];
                        if (idx == IW'(ND - 1)) begin
                            idx     <= '0;
                            wb_cyc  <= 1'b1;
                            wb_stb  <= 1'b1;
                            tcnt    <= '0;
                            p_state <= P_WB;
                        end else if (idx != IW'(NMAX)) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                P_WB: begin
                    if (wb_ack || wb_err) begin
                        wb_cyc  <= 1'b0;
                        wb_stb  <= 1'b0;
                        p_state <= P_SEND;
                        if (wb_err) begin
                            resp_sr   <= {{data_width{1'b0}}, RSP_ERR};
                            send_left <= SW'(1);
                        end else if (wb_we) begin
                            resp_sr   <= {{data_width{1'b0}}, RSP_OK};
                            send_left <= SW'(1);
                        end else begin
                            resp_sr   <= {wb_dat_i, RSP_OK};
                            send_left <= SW'(ND + 1);
                        end
                    end else if (tcnt == TW'(timeout_cycles - 1)) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        resp_sr   <= {{data_width{1'b0}}, RSP_ERR};
                        send_left <= SW'(1);
                        p_state   <= P_SEND;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                P_SEND: begin
                    if (tx_load) begin
                        resp_sr   <= resp_sr >> 8;
                        send_left <= send_left - 1'b1;
                    end else if (send_left == '0 && !tx_active) begin
                        p_state <= P_IDLE;
                    end
                end
                default: p_state <= P_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // UART transmit
    // ------------------------------------------------------------------

    // 10-bit frame shifted out LSB first; a new load pre-empts the end of a stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '1;
            uart_tx   <= 1'b1;
        end else if (tx_load) begin
            tx_shift  <= {1'b1, resp_sr[7:0], 1'b0};
            uart_tx   <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_active <= 1'b1;
        end else if (tx_active) begin
            if (tx_cnt == CW'(clk_per_bit - 1)) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    uart_tx   <= 1'b1;
                end else begin
                    tx_bit   <= tx_bit + 1'b1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    uart_tx  <= tx_shift[1];
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart2wb.sv
// tb/tb_uart2wb.sv - directed table-driven bench for uart2wb
module tb_uart2wb;

    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    uart2wb #(
        .addr_width(32), .data_width(32), .clk_per_bit(CPB), .timeout_cycles(16)
    ) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: mode 0 ack, 1 err, 2 silent, 3 ack+err; responds 3 clocks after stb rises
    int          mode = 0;
    logic [31:0] rdat = '0;
    int          cycle_no = 0;
    int          cyc_count = 0;
    int          rise_cyc = 0;
    int          drop_cyc = 0;
    int          unstable = 0;
    int          wait_cnt = 0;
    logic        in_cyc = 1'b0;
    logic [31:0] l_adr, l_dat;
    logic        l_we;
    logic [3:0]  l_sel;

    always @(posedge clock) begin
        cycle_no++;
        #1;
        if (wb_cyc && wb_stb) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                wait_cnt = 0;
                cyc_count++;
                rise_cyc = cycle_no;
                l_adr = wb_adr;
                l_dat = wb_dat_o;
                l_we  = wb_we;
                l_sel = wb_sel;
            end else begin
                wait_cnt++;
                if (wb_adr !== l_adr || wb_dat_o !== l_dat || wb_we !== l_we) unstable++;
            end
            if (wait_cnt == 2 && mode != 2) begin
                wb_dat_i = rdat;
                wb_ack = (mode == 0 || mode == 3);
                wb_err = (mode == 1 || mode == 3);
            end
        end else begin
            if (in_cyc) begin
                in_cyc = 1'b0;
                drop_cyc = cycle_no;
            end
            wb_ack = 1'b0;
            wb_err = 1'b0;
            wb_dat_i = '0;
        end
    end

    // Response decoder, sampling mid-bit on the falling clock edge
    logic [7:0] rxq[$];

    initial begin : mon
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clock);
                        b[i] = uart_tx;
                    end
                    repeat (CPB) @(negedge clock);
                    rxq.push_back(b);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(we ? 8'h57 : 8'h52, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8], 1'b1);
        if (we) for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8], 1'b1);
    endtask

    task automatic wait_resp(input int n);
        for (int i = 0; i < 4000 && rxq.size() < n; i++) @(posedge clock);
        repeat (120) @(posedge clock);
    endtask

    task automatic check_resp(input string name, input int base, input int n, input logic [39:0] exp);
        logic [7:0] got;
        check({name, " resp_count"}, 32'(rxq.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (base + i < rxq.size()) ? rxq[base + i] : 8'hxx;
            check($sformatf("%s resp_byte%0d", name, i), {24'h0, got}, {24'h0, exp[8*i +: 8]});
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          mode;
        logic [31:0] rdat;
        int          lat;
        int          n;
        logic [39:0] resp;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input string name, input vec_t v);
        int base_c, base_q, base_u;
        base_c = cyc_count;
        base_q = rxq.size();
        base_u = unstable;
        mode = v.mode;
        rdat = v.rdat;
        send_frame(v.we, v.adr, v.wdat);
        wait_resp(base_q + v.n);
        check({name, " cycles"}, 32'(cyc_count - base_c), 32'd1);
        check({name, " adr"}, l_adr, v.adr);
        check({name, " we"}, {31'h0, l_we}, {31'h0, v.we});
        check({name, " sel"}, {28'h0, l_sel}, 32'hF);
        if (v.we) check({name, " dat_o"}, l_dat, v.wdat);
        check({name, " hold"}, 32'(unstable - base_u), 32'd0);
        check({name, " cyc_len"}, 32'(drop_cyc - rise_cyc), 32'(v.lat));
        check_resp(name, base_q, v.n, v.resp);
    endtask

    initial begin
        int base_c, base_q;
        bit seen;

        vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0,         3,  1, 40'h4B};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         0, 32'h1234_5678, 3,  5, 40'h12345678_4B};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         1, 32'h5555_5555, 3,  1, 40'h45};
        vecs[3] = '{1'b1, 32'h0000_0030, 32'h0102_0304, 2, 32'h0,         16, 1, 40'h45};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         3, 32'h7777_7777, 3,  1, 40'h45};
        vecs[5] = '{1'b0, 32'h00AB_CDEF, 32'h0,         0, 32'hA500_5AFF, 3,  5, 40'hA5005AFF_4B};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 1, 32'h0,         3,  1, 40'h45};

        // Reset state
        repeat (4) @(posedge clock);
        #1;
        check("rst uart_tx", {31'h0, uart_tx}, 32'd1);
        check("rst cyc", {31'h0, wb_cyc}, 32'd0);
        check("rst stb", {31'h0, wb_stb}, 32'd0);
        check("rst we", {31'h0, wb_we}, 32'd0);
        check("rst adr", wb_adr, 32'h0);
        check("rst dat_o", wb_dat_o, 32'h0);
        check("rst sel", {28'h0, wb_sel}, 32'hF);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Framing error mid-frame abandons it; the following read is serviced
        base_c = cyc_count;
        base_q = rxq.size();
        mode = 0;
        rdat = 32'hCAFE_F00D;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b0);
        repeat (40) @(negedge clock);
        send_frame(1'b0, 32'h0000_0044, 32'h0);
        wait_resp(base_q + 5);
        check("ferr cycles", 32'(cyc_count - base_c), 32'd1);
        check("ferr adr", l_adr, 32'h0000_0044);
        check("ferr we", {31'h0, l_we}, 32'd0);
        check_resp("ferr", base_q, 5, 40'hCAFEF00D_4B);

        // Unknown command byte and a short low glitch are both ignored
        base_c = cyc_count;
        base_q = rxq.size();
        rdat = 32'h0BAD_CAFE;
        send_byte(8'h00, 1'b1);
        repeat (10) @(negedge clock);
        uart_rx = 1'b0;
        repeat (4) @(negedge clock);
        uart_rx = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(1'b0, 32'h0000_0008, 32'h0);
        wait_resp(base_q + 5);
        check("glitch cycles", 32'(cyc_count - base_c), 32'd1);
        check("glitch adr", l_adr, 32'h0000_0008);
        check_resp("glitch", base_q, 5, 40'h0BADCAFE_4B);

        // Reset while waiting on a silent slave
        mode = 2;
        fork
            send_frame(1'b1, 32'h0000_0100, 32'h1111_2222);
        join_none
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            seen = wb_cyc;
        end
        check("rstwb reached", {31'h0, seen}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rstwb cyc", {31'h0, wb_cyc}, 32'd0);
        check("rstwb stb", {31'h0, wb_stb}, 32'd0);
        check("rstwb uart_tx", {31'h0, uart_tx}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        // Reset while the read response is being sent
        mode = 0;
        rdat = 32'h9999_8888;
        fork
            send_frame(1'b0, 32'h0000_0200, 32'h0);
        join_none
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clock);
            seen = (uart_tx === 1'b0);
        end
        check("rsttx reached", {31'h0, seen}, 32'd1);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rsttx uart_tx", {31'h0, uart_tx}, 32'd1);
        check("rsttx cyc", {31'h0, wb_cyc}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (200) @(negedge clock);

        // Normal service after both resets
        run_vec("post_rst", vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        repeat (90000) @(posedge clock);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
